pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
Parametrised, pipelined successor to the 4-bit ripple-carry adder. Adds or subtracts two WIDTH-bit operands, one ripple chunk of CHUNK bits per pipeline stage. Stages pass the carry between them through registers. Has a valid/ready handshake on input and output. Produces carry-out and signed overflow. Feeds the lab ALU datapath, where a wide single-cycle ripple chain would limit Clock frequency.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per pipeline stage (ripple length per stage).
STAGES, WIDTH/CHUNK (derived localparam, not overridable), pipeline depth = latency in cycles.

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  asynchronous active-low reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts operand this cycle
a  input  WIDTH  operand A, unsigned or two's complement
b  input  WIDTH  operand B
c_in  input  1  carry-in for add; ignored when sub=1
sub  input  1  1 = A - B, 0 = A + B + c_in
out_valid  output  1  result beat present
out_ready  input  1  consumer accepts result this cycle
s  output  WIDTH  sum/difference
c_out  output  1  carry out of MSB; for subtract, 1 = no borrow
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Stage k (0..STAGES-1) registers the following:
  - a valid bit;
  - the result bits of chunks 0..k;
  - the still-unconsumed upper operand bits (B already inverted when subtracting);
  - the carry out of chunk k.
- Stage 0 adds chunk 0 of A and B_eff with cin_eff.
  - B_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : c_in.
- Stage k adds its chunk using the registered carry from stage k-1.
- The last stage also registers the carry into the MSB, used for ovf.
- Stage advance rule:
  - stage k loads when stage k is empty, or stage k+1 will load this cycle;
  - the last stage loads when it is empty or out_ready=1.
- in_ready = !valid[0] | advance[0]. This is combinational from out_ready through the chain; no registered skid buffer.
- Latency: exactly STAGES cycles from accepted input to out_valid, provided out_ready stays high.
- Throughput: one operation per cycle while out_ready stays high.
- Capacity: STAGES operations in flight.
- Backpressure: with out_ready=0, the pipeline compacts and bubbles are squeezed out. in_ready drops only when all stages are valid. Order is preserved; no operation is dropped or duplicated.
- Outputs s, c_out and ovf are taken directly from last-stage registers. They hold stable while out_valid=1 and out_ready=0.
- Reset (Resetn=0, asynchronous):
  - all valid bits, data registers and carries clear to 0;
  - out_valid=0, s=0, c_out=0, ovf=0, in_ready=1.
  - In-flight operations are discarded and never emerge after release.
  - Reset asserted mid-transfer takes priority over everything.
- Wrap-around: the sum is taken modulo 2^WIDTH. The carry appears only on c_out.
- Subtraction semantics: A + ~B + 1. c_out=0 means a borrow occurred.
- Simultaneous input and output transfer in the same cycle is legal at full occupancy.
- WIDTH % CHUNK != 0 causes an elaboration-time error.

Decomposition:
- Shared package addsub_pkg holds:
  - opcode constants OP_ADD=1'b0 and OP_SUB=1'b1;
  - a function checking that WIDTH is a multiple of CHUNK.
- Sub-module ripple_chunk, parametrised by CHUNK:
  - a combinational full-adder chain;
  - inputs a, b, cin;
  - outputs s, cout, and c_msb (the carry into the top bit).
- pipelined_addsub instantiates ripple_chunk once per stage (generate loop) and holds all registers and handshake logic.

Test Plan:
- WIDTH=16, CHUNK=4, out_ready=1; a=0x1234, b=0x0FED, c_in=0, sub=0 -> after 4 cycles out_valid=1, s=0x2221, c_out=0, ovf=0.
- Full carry ripple through all stages: a=0xFFFF, b=0x0000, c_in=1 -> s=0x0000, c_out=1, ovf=0. Then a=0x7FFF, b=0x0001 -> s=0x8000, c_out=0, ovf=1.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, c_in=1 (must be ignored) -> s=0xFFFE, c_out=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, c_out=1, ovf=1.
- Backpressure: stream 8 back-to-back random operations, with out_ready=0 on cycles 3-9 -> in_ready falls after 4 operations are held. All 8 results later emerge in order, matching the reference model. Outputs are stable while stalled.
- Reset mid-flight: 3 operations accepted, then Resetn=0 for 1 cycle between clock edges -> out_valid, s, c_out and ovf read 0 immediately. After release, none of the 3 results appear; a new operation completes with latency 4.
- Parameter sweep: WIDTH=8/CHUNK=8 (latency 1) and WIDTH=32/CHUNK=4 (latency 8) -> 10k random add/sub operations with random in_valid/out_ready all match the model. WIDTH=10/CHUNK=4 fails elaboration.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: opcode encoding and a
// parameter sanity check used at elaboration time.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/ripple_chunk.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into the
// top bit so the caller can derive signed overflow.
module ripple_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic carry;

    // Carry is walked bit by bit in one process so the chain stays a single
    // acyclic combinational path.
    always_comb begin
        s     = '0;
        c_msb = 1'b0;
        carry = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit adder/subtractor split into CHUNK-bit ripple stages with a
// valid/ready handshake on both ends; one stage per clock, compacting on stall.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
        $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    // Per-stage state
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic              cmsb_q, cmsb_d;

    // What each stage would load this cycle
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_cin;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_res [STAGES];

    logic [CHUNK-1:0]  sum_chunk [STAGES];
    logic [STAGES-1:0] cout_chunk;
    logic [STAGES-1:0] cmsb_chunk;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] merged;

        if (gi == 0) begin : g_head
            assign src_valid[gi] = in_valid;
            assign src_a[gi]     = a;
            assign src_b[gi]     = (sub == OP_ADD) ? b : ~b;
            assign src_cin[gi]   = (sub == OP_SUB) ? 1'b1 : c_in;
            assign src_res[gi]   = '0;
        end else begin : g_body
            assign src_valid[gi] = valid_q[gi-1];
            assign src_a[gi]     = opa_q[gi-1];
            assign src_b[gi]     = opb_q[gi-1];
            assign src_cin[gi]   = carry_q[gi-1];
            assign src_res[gi]   = res_q[gi-1];
        end

        // A stage may advance if it, or any stage downstream of it, is empty,
        // or the consumer takes the result; written flat to avoid a
        // combinational chain through adv itself.
        assign adv[gi]  = out_ready | ~(&valid_q[STAGES-1:gi]);
        assign load[gi] = adv[gi] & src_valid[gi];

        ripple_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a     (src_a[gi][gi*CHUNK +: CHUNK]),
            .b     (src_b[gi][gi*CHUNK +: CHUNK]),
            .cin   (src_cin[gi]),
            .s     (sum_chunk[gi]),
            .cout  (cout_chunk[gi]),
            .c_msb (cmsb_chunk[gi])
        );

        always_comb begin
            merged                      = src_res[gi];
            merged[gi*CHUNK +: CHUNK]   = sum_chunk[gi];
        end

        assign valid_d[gi] = adv[gi] ? src_valid[gi] : valid_q[gi];
        assign carry_d[gi] = load[gi] ? cout_chunk[gi] : carry_q[gi];
        assign res_d[gi]   = load[gi] ? merged : res_q[gi];
        assign opa_d[gi]   = load[gi] ? src_a[gi] : opa_q[gi];
        assign opb_d[gi]   = load[gi] ? src_b[gi] : opb_q[gi];
    end

    assign cmsb_d = load[STAGES-1] ? cmsb_chunk[STAGES-1] : cmsb_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            valid_q <= '0;
            carry_q <= '0;
            cmsb_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            res_q   <= res_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[STAGES-1];
    assign s         = res_q[STAGES-1];
    assign c_out     = carry_q[STAGES-1];
    assign ovf       = carry_q[STAGES-1] ^ cmsb_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=16, CHUNK=4): directed vector table,
// streaming, backpressure, mid-flight reset and a randomized handshake run.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int ST = W / CH;

    logic         Clock = 1'b0;
    logic         Resetn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;

    pipelined_addsub #(
        .WIDTH (W),
        .CHUNK (CH)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         op;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];
    res_t exp_q [$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int n_acc = 0;
    int n_out = 0;
    bit rnd_done;

    always @(posedge Clock) cyc <= cyc + 1;

    // Reference: plain integer arithmetic, borrow-style carry for subtract
    function automatic res_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic xc, input logic xo);
        res_t r;
        logic [W:0] t;
        if (xo == OP_SUB) begin
            t   = {1'b0, xa} - {1'b0, xb};
            r.c = ~t[W];
            r.v = (xa[W-1] != xb[W-1]) && (t[W-1] != xa[W-1]);
        end else begin
            t   = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
            r.c = t[W];
            r.v = (xa[W-1] == xb[W-1]) && (t[W-1] != xa[W-1]);
        end
        r.s = t[W-1:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Output scoreboard: every output transfer is matched against the queue
    always @(negedge Clock) begin
        res_t e;
        if (Resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got s=%h c=%b v=%b want no output", s, c_out, ovf);
            end else begin
                e = exp_q.pop_front();
                if (s !== e.s || c_out !== e.c || ovf !== e.v) begin
                    bad++;
                    $display("FAIL result #%0d: got s=%h c=%b v=%b want s=%h c=%b v=%b",
                             n_out, s, c_out, ovf, e.s, e.c, e.v);
                end else begin
                    $display("out #%0d s=%h c_out=%b ovf=%b ok", n_out, s, c_out, ovf);
                end
            end
            n_out++;
        end
    end

    // Presents one operand beat and holds it until accepted (bounded)
    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input logic xo, input res_t e);
        bit done = 0;
        int waited = 0;
        a = xa; b = xb; c_in = xc; sub = xo; in_valid = 1'b1;
        while (!done) begin
            @(negedge Clock);
            if (in_ready === 1'b1) begin
                exp_q.push_back(e);
                acc_cyc = cyc;
                n_acc++;
                done = 1;
            end else if (waited > 50) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout: got in_ready=%b want 1 within 50 cycles", in_ready);
                done = 1;
            end
            waited++;
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic send_random();
        logic [W-1:0] ra, rb;
        logic rc, ro;
        ra = W'($urandom());
        rb = W'($urandom());
        rc = 1'($urandom());
        ro = 1'($urandom());
        send(ra, rb, rc, ro, model(ra, rb, rc, ro));
    endtask

    task automatic wait_latency(input string name);
        int lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (out_valid === 1'b1) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
        check(name, lat, ST);
        @(posedge Clock);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge Clock);
        check(name, exp_q.size(), 0);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hs;
        logic hc, hv;
        int first, n0, acc0;

        vecs[0]  = '{16'h1234, 16'h0FED, 1'b0, OP_ADD, 16'h2221, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b1, OP_SUB, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h1234, 16'h0FED, 1'b1, OP_ADD, 16'h2222, 1'b0, 1'b0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b0, OP_ADD, 16'hFFFE, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b0, OP_SUB, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0001, 1'b0, OP_SUB, 16'hFFFF, 1'b0, 1'b0};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, OP_SUB, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{16'hABCD, 16'h1111, 1'b0, OP_ADD, 16'hBCDE, 1'b0, 1'b0};
        vecs[12] = '{16'h4000, 16'h4000, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1};

        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0; sub = OP_ADD;
        Resetn = 1'b1;
        #1 Resetn = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_s", 32'(s), 0);
        check("reset_c_out", 32'(c_out), 0);
        check("reset_ovf", 32'(ovf), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        repeat (3) @(posedge Clock);
        #2 Resetn = 1'b1;
        @(posedge Clock);
        #1;

        // One operation at a time: latency plus table-expected results
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op,
                 '{vecs[i].s, vecs[i].c, vecs[i].v});
            in_valid = 1'b0;
            wait_latency($sformatf("latency_vec%0d", i));
        end
        drain("drain_single");

        // Back-to-back: one accept per cycle
        first = 0;
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op,
                 '{vecs[i].s, vecs[i].c, vecs[i].v});
            if (i == 0) first = acc_cyc;
        end
        in_valid = 1'b0;
        check("stream_throughput", acc_cyc - first, NVEC - 1);
        drain("drain_stream");

        // Backpressure: pipeline fills to ST then stalls input, outputs held
        out_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                for (int i = 0; i < 8; i++) send_random();
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(negedge Clock);
                check("bp_in_ready_low", 32'(in_ready), 0);
                check("bp_held_count", n_acc - acc0, ST);
                check("bp_out_valid", 32'(out_valid), 1);
                hs = s; hc = c_out; hv = ovf;
                @(negedge Clock);
                check("bp_stable_s", 32'(s), 32'(hs));
                check("bp_stable_c", 32'(c_out), 32'(hc));
                check("bp_stable_v", 32'(ovf), 32'(hv));
                @(posedge Clock);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Reset with operations in flight
        out_ready = 1'b0;
        send(16'h1234, 16'h0FED, 1'b0, OP_ADD, model(16'h1234, 16'h0FED, 1'b0, OP_ADD));
        send(16'h1111, 16'h2222, 1'b0, OP_ADD, model(16'h1111, 16'h2222, 1'b0, OP_ADD));
        send(16'h9000, 16'h0001, 1'b0, OP_SUB, model(16'h9000, 16'h0001, 1'b0, OP_SUB));
        in_valid = 1'b0;
        repeat (2) @(posedge Clock);
        #2;
        check("prereset_out_valid", 32'(out_valid), 1);
        check("prereset_s", 32'(s), 32'h2221);
        Resetn = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 0);
        check("midreset_s", 32'(s), 0);
        check("midreset_c_out", 32'(c_out), 0);
        check("midreset_ovf", 32'(ovf), 0);
        check("midreset_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        @(posedge Clock);
        #2 Resetn = 1'b1;
        #1 out_ready = 1'b1;
        n0 = n_out;
        repeat (10) @(negedge Clock);
        check("no_ghost_outputs", n_out - n0, 0);
        @(posedge Clock);
        #1;
        send(16'h0F0F, 16'h00F1, 1'b0, OP_ADD, '{16'h1000, 1'b0, 1'b0});
        in_valid = 1'b0;
        wait_latency("latency_after_reset");
        drain("drain_after_reset");

        // Random operands with random gaps and random consumer stalls
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge Clock);
                        #1;
                    end
                    send_random();
                end
                in_valid = 1'b0;
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge Clock);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("drain_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
